// File: rtl/local_mac_acc.sv
// Bit-serial local MAC: ANDs each input bit-plane with a weight slice, counts the ones and
// shift-accumulates the counts MSB plane first into a multi-bit dot product.
module local_mac_acc #(
    parameter int unsigned INPUT_WIDTH = 144,
    parameter int unsigned PSUM_WIDTH  = 12,
    parameter int unsigned IN_BITS     = 8,
    parameter int unsigned ACC_WIDTH   = PSUM_WIDTH + IN_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   signed_mode,
    input  logic [INPUT_WIDTH-1:0] wb,
    input  logic [INPUT_WIDTH-1:0] rwlb,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   psum_out
);

    localparam int unsigned CntW = $clog2(IN_BITS + 1);
    localparam longint unsigned MaxMag =
        longint'(INPUT_WIDTH) * ((longint'(1) << IN_BITS) - 1);

    // Parameter sanity: popcount must fit PSUM_WIDTH, worst-case result must fit ACC_WIDTH.
    if (IN_BITS < 2) begin : g_bits_err
        $error("local_mac_acc: IN_BITS must be at least 2");
    end
    if ((longint'(1) << PSUM_WIDTH) <= longint'(INPUT_WIDTH)) begin : g_psum_err
        $error("local_mac_acc: PSUM_WIDTH too small for INPUT_WIDTH");
    end
    if (MaxMag >= (longint'(1) << (ACC_WIDTH - 1))) begin : g_acc_err
        $error("local_mac_acc: ACC_WIDTH too small for worst-case result");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_t;

    state_t                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic                   signed_q;
    logic [INPUT_WIDTH-1:0] prod;
    logic [PSUM_WIDTH-1:0]  pc;
    logic [PSUM_WIDTH-1:0]  pc_q;
    logic                   pc_valid_q;
    logic                   first_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   pc_ext;
    logic                   xfer;

    assign xfer     = in_valid & in_ready;
    assign prod     = wb & rwlb;
    assign pc_ext   = {{(ACC_WIDTH - PSUM_WIDTH){1'b0}}, pc_q};
    assign psum_out = acc_q;

    // Popcount of the AND product.
    always_comb begin
        pc = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            pc = pc + PSUM_WIDTH'(prod[i]);
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        state_q  <= StAccum;
                        cnt_q    <= CntW'(1);
                        signed_q <= signed_mode;
                    end
                end
                StAccum: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(IN_BITS - 1)) begin
                            state_q  <= StDrain;
                            in_ready <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    // Only the last plane can be in stage 1 here; it lands in acc this edge.
                    if (pc_valid_q) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Two-stage datapath: registered popcount, then shift-accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            first_q    <= 1'b0;
            acc_q      <= '0;
        end else if (clear) begin
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            first_q    <= 1'b0;
            acc_q      <= '0;
        end else begin
            pc_valid_q <= xfer;
            first_q    <= xfer && (state_q == StIdle);
            if (xfer) begin
                pc_q <= pc;
            end
            if (pc_valid_q) begin
                if (first_q) begin
                    // MSB plane carries negative weight in two's-complement mode.
                    acc_q <= signed_q ? -pc_ext : pc_ext;
                end else begin
                    acc_q <= (acc_q << 1) + pc_ext;
                end
            end
        end
    end

endmodule
